// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues taken-branch mispredicts for BTB writeback,
// coalesces repeat updates to the newest entry and raises fetch redirects.
module btb_update_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BPU__Stall,
  input  logic        EX_Valid,
  input  logic [31:0] EX_PC,
  input  logic        EX_Taken,
  input  logic [31:0] EX_Target,
  input  logic        EX_Pred_Hit,
  input  logic [31:0] EX_Pred_Target,
  output logic [31:0] BTB_Write_Addr,
  output logic [31:0] BTB_Write_Data,
  output logic        BTB_Write_En,
  output logic        Redirect,
  output logic [31:0] Redirect_PC,
  output logic        Queue_Full,
  output logic [15:0] Drop_Count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   tgt_mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, tail;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          redir_q;
  logic [31:0]   redir_pc_q, redir_pc_d;
  logic [15:0]   drop_q, drop_d;

  logic cand, mispred, empty, full, deq, coal, enq, drop;

  assign cand    = EX_Valid & EX_Taken & (~EX_Pred_Hit | (EX_Pred_Target != EX_Target));
  assign mispred = cand | (EX_Valid & ~EX_Taken & EX_Pred_Hit);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign deq     = ~empty & ~BPU__Stall;
  assign tail    = wr_ptr_q - AW'(1);

  // A lone entry leaving this cycle cannot absorb the candidate; it re-enqueues.
  assign coal = cand & ~empty & (pc_mem[tail] == EX_PC) & ~(deq & (cnt_q == CW'(1)));
  assign enq  = cand & ~coal & (~full | deq);
  assign drop = cand & ~coal & full & ~deq;

  always_comb begin
    rd_ptr_d   = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cnt_d      = cnt_q;
    if (enq && !deq)      cnt_d = cnt_q + CW'(1);
    else if (!enq && deq) cnt_d = cnt_q - CW'(1);
    redir_pc_d = redir_pc_q;
    if (mispred) redir_pc_d = EX_Taken ? EX_Target : EX_PC + 32'd4;
    drop_d     = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      drop_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      redir_q    <= mispred;
      redir_pc_q <= redir_pc_d;
      drop_q     <= drop_d;
    end
  end

  // Payload carries no reset; occupancy gates every read of it.
  always_ff @(posedge CLK) begin
    if (enq) begin
      pc_mem[wr_ptr_q]  <= EX_PC;
      tgt_mem[wr_ptr_q] <= EX_Target;
    end else if (coal) begin
      tgt_mem[tail] <= EX_Target;
    end
  end

  assign BTB_Write_En   = deq;
  assign BTB_Write_Addr = empty ? 32'd0 : pc_mem[rd_ptr_q];
  assign BTB_Write_Data = empty ? 32'd0 : tgt_mem[rd_ptr_q];
  assign Redirect       = redir_q;
  assign Redirect_PC    = redir_pc_q;
  assign Queue_Full     = full;
  assign Drop_Count     = drop_q;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: hand-computed expectations per step.
module tb_btb_update_ctrl;
  logic        CLK, RST, BPU__Stall, EX_Valid, EX_Taken, EX_Pred_Hit;
  logic [31:0] EX_PC, EX_Target, EX_Pred_Target;
  logic [31:0] BTB_Write_Addr, BTB_Write_Data, Redirect_PC;
  logic        BTB_Write_En, Redirect, Queue_Full;
  logic [15:0] Drop_Count;
  int checks = 0;
  int errors = 0;

  btb_update_ctrl #(.DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .BPU__Stall(BPU__Stall), .EX_Valid(EX_Valid),
    .EX_PC(EX_PC), .EX_Taken(EX_Taken), .EX_Target(EX_Target),
    .EX_Pred_Hit(EX_Pred_Hit), .EX_Pred_Target(EX_Pred_Target),
    .BTB_Write_Addr(BTB_Write_Addr), .BTB_Write_Data(BTB_Write_Data),
    .BTB_Write_En(BTB_Write_En), .Redirect(Redirect), .Redirect_PC(Redirect_PC),
    .Queue_Full(Queue_Full), .Drop_Count(Drop_Count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                    input logic hit, input logic [31:0] ptgt);
    EX_Valid = 1'b1; EX_PC = pc; EX_Taken = tk; EX_Target = tgt;
    EX_Pred_Hit = hit; EX_Pred_Target = ptgt;
  endtask

  task automatic idle();
    EX_Valid = 1'b0; EX_Taken = 1'b0; EX_Pred_Hit = 1'b0;
    EX_PC = 32'd0; EX_Target = 32'd0; EX_Pred_Target = 32'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input string tag, input logic en, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_en"},   32'(en), 32'(en === 1'b1 ? BTB_Write_En : ~BTB_Write_En) == 32'd1 ? 32'(en) : 32'(BTB_Write_En));
    chk({tag, "_addr"}, BTB_Write_Addr, a);
    chk({tag, "_data"}, BTB_Write_Data, d);
  endtask

  initial begin
    RST = 1'b0; BPU__Stall = 1'b0;
    idle();
    #2;
    chk("rst_we",    32'(BTB_Write_En), 32'd0);
    chk("rst_full",  32'(Queue_Full),   32'd0);
    chk("rst_redir", 32'(Redirect),     32'd0);
    chk("rst_rpc",   Redirect_PC,       32'd0);
    chk("rst_drop",  32'(Drop_Count),   32'd0);
    chk("rst_addr",  BTB_Write_Addr,    32'd0);
    tick(); tick();
    RST = 1'b1;

    // Miss allocate
    ex(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    tick(); idle();
    chk("alloc_redir", 32'(Redirect), 32'd1);
    chk("alloc_rpc",   Redirect_PC,   32'h200);
    chk("alloc_we",    32'(BTB_Write_En), 32'd1);
    chk("alloc_addr",  BTB_Write_Addr, 32'h100);
    chk("alloc_data",  BTB_Write_Data, 32'h200);
    tick();
    chk("alloc_redir_off", 32'(Redirect), 32'd0);
    chk("alloc_rpc_hold",  Redirect_PC,   32'h200);
    chk("alloc_we_off",    32'(BTB_Write_En), 32'd0);
    chk("alloc_empty",     BTB_Write_Addr, 32'd0);

    // Not-taken false hit, then a correct prediction
    ex(32'h300, 1'b0, 32'h999, 1'b1, 32'h999);
    tick(); idle();
    chk("nt_redir", 32'(Redirect), 32'd1);
    chk("nt_rpc",   Redirect_PC,   32'h304);
    chk("nt_we",    32'(BTB_Write_En), 32'd0);
    chk("nt_addr",  BTB_Write_Addr, 32'd0);
    ex(32'h400, 1'b1, 32'h500, 1'b1, 32'h500);
    tick(); idle();
    chk("ok_redir", 32'(Redirect), 32'd0);
    chk("ok_rpc",   Redirect_PC,   32'h304);
    chk("ok_we",    32'(BTB_Write_En), 32'd0);
    chk("ok_addr",  BTB_Write_Addr, 32'd0);

    // Stall fill: four accepted, fifth dropped
    BPU__Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ex(32'h10 * (i + 1), 1'b1, 32'h1000 + i, 1'b0, 32'h0);
      tick();
      if (i == 2) chk("fill_notfull", 32'(Queue_Full), 32'd0);
      if (i == 3) chk("fill_full",    32'(Queue_Full), 32'd1);
    end
    idle();
    chk("fill_drop",   32'(Drop_Count), 32'd1);
    chk("fill_full2",  32'(Queue_Full), 32'd1);
    chk("fill_we_stl", 32'(BTB_Write_En), 32'd0);
    chk("fill_head",   BTB_Write_Addr, 32'h10);
    BPU__Stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_we",   32'(BTB_Write_En), 32'd1);
      chk("drain_addr", BTB_Write_Addr, 32'h10 * (i + 1));
      chk("drain_data", BTB_Write_Data, 32'h1000 + i);
      tick();
    end
    chk("drain_done", 32'(BTB_Write_En), 32'd0);
    chk("drain_full", 32'(Queue_Full),   32'd0);

    // Coalesce under stall
    BPU__Stall = 1'b1;
    ex(32'h80, 1'b1, 32'h900, 1'b0, 32'h0);
    tick();
    ex(32'h80, 1'b1, 32'hA00, 1'b1, 32'h900);
    tick(); idle();
    chk("coal_data_stl", BTB_Write_Data, 32'hA00);
    BPU__Stall = 1'b0;
    #1;
    chk("coal_we",   32'(BTB_Write_En), 32'd1);
    chk("coal_addr", BTB_Write_Addr, 32'h80);
    chk("coal_data", BTB_Write_Data, 32'hA00);
    tick();
    chk("coal_single", 32'(BTB_Write_En), 32'd0);

    // Lone head being dequeued does not absorb a same-PC candidate
    BPU__Stall = 1'b1;
    ex(32'h70, 1'b1, 32'h700, 1'b0, 32'h0);
    tick();
    BPU__Stall = 1'b0;
    ex(32'h70, 1'b1, 32'h7A0, 1'b0, 32'h0);
    #1;
    chk("ht_we0",   32'(BTB_Write_En), 32'd1);
    chk("ht_data0", BTB_Write_Data, 32'h700);
    tick(); idle();
    chk("ht_we1",   32'(BTB_Write_En), 32'd1);
    chk("ht_addr1", BTB_Write_Addr, 32'h70);
    chk("ht_data1", BTB_Write_Data, 32'h7A0);
    tick();
    chk("ht_empty", 32'(BTB_Write_En), 32'd0);

    // Full with simultaneous dequeue accepts the new miss
    BPU__Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex(32'hA0 + 32'h10 * i, 1'b1, 32'h2000 + i, 1'b0, 32'h0);
      tick();
    end
    chk("fd_full", 32'(Queue_Full), 32'd1);
    BPU__Stall = 1'b0;
    ex(32'h60, 1'b1, 32'h6000, 1'b0, 32'h0);
    #1;
    chk("fd_we",   32'(BTB_Write_En), 32'd1);
    chk("fd_addr", BTB_Write_Addr, 32'hA0);
    tick(); idle();
    BPU__Stall = 1'b1;
    #1;
    chk("fd_still_full", 32'(Queue_Full), 32'd1);
    chk("fd_drop",       32'(Drop_Count), 32'd1);
    chk("fd_head",       BTB_Write_Addr, 32'hB0);
    BPU__Stall = 1'b0;
    tick(); tick(); tick();
    chk("fd_tail_we",   32'(BTB_Write_En), 32'd1);
    chk("fd_tail_addr", BTB_Write_Addr, 32'h60);
    chk("fd_tail_data", BTB_Write_Data, 32'h6000);
    tick();
    chk("fd_empty", 32'(BTB_Write_En), 32'd0);

    // Async reset with three queued entries
    BPU__Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex(32'h11 * (i + 1), 1'b1, 32'h3000 + i, 1'b0, 32'h0);
      tick();
    end
    idle();
    BPU__Stall = 1'b0;
    #1;
    chk("ar_pre_we",    32'(BTB_Write_En), 32'd1);
    chk("ar_pre_redir", 32'(Redirect),     32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("ar_we",    32'(BTB_Write_En), 32'd0);
    chk("ar_full",  32'(Queue_Full),   32'd0);
    chk("ar_redir", 32'(Redirect),     32'd0);
    chk("ar_rpc",   Redirect_PC,       32'd0);
    chk("ar_drop",  32'(Drop_Count),   32'd0);
    #2;
    RST = 1'b1;
    tick();
    chk("ar_post_we0", 32'(BTB_Write_En), 32'd0);
    tick();
    chk("ar_post_we1",   32'(BTB_Write_En), 32'd0);
    chk("ar_post_addr",  BTB_Write_Addr, 32'd0);
    ex(32'h44, 1'b1, 32'h4400, 1'b0, 32'h0);
    tick(); idle();
    chk("ar_new_we",   32'(BTB_Write_En), 32'd1);
    chk("ar_new_addr", BTB_Write_Addr, 32'h44);
    chk("ar_new_data", BTB_Write_Data, 32'h4400);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
